// File: rtl/imm_encoder.sv
// Inverse of the immediate extender: turns a 32-bit constant into one
// (imm, eop) beat, or a lui/ori pair when no single extender mode reproduces it.
module imm_encoder #(
  parameter bit ENABLE_SHIFT = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic             out_last,
  output logic             out_split,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] split_cnt
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t      state, state_next;
  logic [15:0] held_lo;
  logic        accept, out_fire;

  logic        fit_sign, fit_zero, fit_upper, fit_shift;
  logic [15:0] enc_imm;
  logic [1:0]  enc_eop;
  logic        enc_single;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Mode selection: first matching extender mode wins; otherwise beat 1 of a split.
  always_comb begin
    fit_sign   = (&in_value[31:15]) || (~|in_value[31:15]);
    fit_zero   = ~|in_value[31:16];
    fit_upper  = ~|in_value[15:0];
    fit_shift  = ENABLE_SHIFT && (in_value[1:0] == 2'b00) &&
                 (in_value[31:17] == {15{in_value[17]}});
    enc_imm    = in_value[31:16];
    enc_eop    = 2'b10;
    enc_single = 1'b1;
    if (fit_sign) begin
      enc_imm = in_value[15:0];
      enc_eop = 2'b00;
    end else if (fit_zero) begin
      enc_imm = in_value[15:0];
      enc_eop = 2'b01;
    end else if (fit_upper) begin
      enc_imm = in_value[31:16];
      enc_eop = 2'b10;
    end else if (fit_shift) begin
      enc_imm = in_value[17:2];
      enc_eop = 2'b11;
    end else begin
      enc_single = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EMIT1;
      EMIT1:   if (out_fire) state_next = out_last ? IDLE : EMIT2;
      EMIT2:   if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Output beat registers, held low half for the ori beat, and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_lo    <= '0;
      out_imm    <= '0;
      out_eop    <= '0;
      out_last   <= 1'b0;
      out_split  <= 1'b0;
      single_cnt <= '0;
      split_cnt  <= '0;
    end else if (accept) begin
      held_lo   <= in_value[15:0];
      out_imm   <= enc_imm;
      out_eop   <= enc_eop;
      out_last  <= enc_single;
      out_split <= ~enc_single;
      if (enc_single) begin
        if (single_cnt != '1) single_cnt <= single_cnt + CNT_W'(1);
      end else begin
        if (split_cnt != '1) split_cnt <= split_cnt + CNT_W'(1);
      end
    end else if ((state == EMIT1) && out_fire && !out_last) begin
      out_imm   <= held_lo;
      out_eop   <= 2'b01;
      out_last  <= 1'b1;
      out_split <= 1'b1;
    end
  end

endmodule
